// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

   localparam int unsigned IC_LINES  = 64;
   localparam int unsigned IC_WORDS  = 4;
   localparam int unsigned IC_ADDR_W = 30;
   localparam int unsigned IC_OFF_W  = $clog2(IC_WORDS);
   localparam int unsigned IC_IDX_W  = $clog2(IC_LINES);
   localparam int unsigned IC_TAG_W  = IC_ADDR_W - IC_IDX_W - IC_OFF_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REFILL = 2'd1,
      ST_ERR    = 2'd2
   } ic_state_e;

endpackage

// File: rtl/icache_data_ram.sv
// Cache data store: one refill write port and one synchronous read port whose
// output register holds until the next read or clear.
module icache_data_ram #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          rd_en,
   input  logic          rd_clr,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Faulted fetches return zero instead of stale array contents.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    rd_data <= '0;
      else if (rd_clr) rd_data <= '0;
      else if (rd_en)  rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with line refill over a single-outstanding bus.
// Optional ICACHE_FLUSH_EN adds the ic_flush invalidate-all input.
module icache
   import icache_pkg::*;
#(
   parameter int unsigned LINES = IC_LINES,
   parameter int unsigned WORDS = IC_WORDS
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fe_req,
   input  logic [31:2] fe_addr,
   output logic        fe_ack,
   output logic        fe_error,
   output logic [31:0] fe_data,
   output logic        mem_req,
   output logic [31:2] mem_addr,
   input  logic        mem_ack,
   input  logic        mem_error,
   input  logic [31:0] mem_rdata
`ifdef ICACHE_FLUSH_EN
   ,input  logic        ic_flush
`endif
);

   localparam int unsigned OFF_W  = $clog2(WORDS);
   localparam int unsigned IDX_W  = $clog2(LINES);
   localparam int unsigned LINE_W = IC_ADDR_W - OFF_W;
   localparam int unsigned TAG_W  = LINE_W - IDX_W;

   ic_state_e           state_q, state_d;
   logic [OFF_W-1:0]    beat_q, beat_d, beat_nxt;
   logic [LINE_W-1:0]   line_q, line_d;
   logic                mem_req_d;
   logic [31:2]         mem_addr_d;
   logic [LINES-1:0]    valid_q;
   logic [TAG_W-1:0]    tag_q [LINES];

   logic [LINE_W-1:0]   fe_line;
   logic [IDX_W-1:0]    fe_idx;
   logic [OFF_W-1:0]    fe_off;
   logic [TAG_W-1:0]    fe_tag;
   logic [IDX_W-1:0]    miss_idx;
   logic                hit;
   logic                rd_en, rd_clr, wr_en, fill_done, clr_line, mark_valid;
   logic                flush_now, flush_pend_q;

   assign fe_line  = fe_addr[31:OFF_W+2];
   assign fe_idx   = fe_addr[IDX_W+OFF_W+1:OFF_W+2];
   assign fe_off   = fe_addr[OFF_W+1:2];
   assign fe_tag   = fe_addr[31:IDX_W+OFF_W+2];
   assign miss_idx = line_q[IDX_W-1:0];
   assign beat_nxt = beat_q + OFF_W'(1);
   assign hit      = valid_q[fe_idx] && (tag_q[fe_idx] == fe_tag);

   // Next-state, bus request and fetch handshake.
   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      line_d     = line_q;
      mem_req_d  = mem_req;
      mem_addr_d = mem_addr;
      fe_ack     = 1'b0;
      fe_error   = 1'b0;
      rd_en      = 1'b0;
      rd_clr     = 1'b0;
      wr_en      = 1'b0;
      fill_done  = 1'b0;
      clr_line   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (fe_req && hit) begin
               fe_ack = 1'b1;
               rd_en  = 1'b1;
            end else if (fe_req) begin
               state_d    = ST_REFILL;
               line_d     = fe_line;
               beat_d     = '0;
               clr_line   = 1'b1;
               mem_req_d  = 1'b1;
               mem_addr_d = {fe_line, OFF_W'(0)};
            end
         end
         ST_REFILL: begin
            if (mem_ack && mem_error) begin
               state_d   = ST_ERR;
               beat_d    = '0;
               mem_req_d = 1'b0;
            end else if (mem_ack) begin
               wr_en      = 1'b1;
               beat_d     = beat_nxt;
               mem_addr_d = {line_q, beat_nxt};
               if (beat_q == OFF_W'(WORDS - 1)) begin
                  fill_done = 1'b1;
                  state_d   = ST_IDLE;
                  mem_req_d = 1'b0;
               end
            end
         end
         ST_ERR: begin
            state_d = ST_IDLE;
            if (fe_req && (fe_line == line_q)) begin
               fe_ack   = 1'b1;
               fe_error = 1'b1;
               rd_clr   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         beat_q   <= '0;
         line_q   <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         line_q   <= line_d;
         mem_req  <= mem_req_d;
         mem_addr <= mem_addr_d;
      end
   end

`ifdef ICACHE_FLUSH_EN
   assign flush_now = ic_flush;

   // A flush seen during a refill keeps that refill from being marked valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                    flush_pend_q <= 1'b0;
      else if (state_d != ST_REFILL)   flush_pend_q <= 1'b0;
      else if (state_q == ST_REFILL)   flush_pend_q <= flush_pend_q | ic_flush;
   end
`else
   assign flush_now    = 1'b0;
   assign flush_pend_q = 1'b0;
`endif

   assign mark_valid = fill_done && !flush_now && !flush_pend_q;

   // The victim line is invalidated as soon as its refill starts overwriting data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
      end else if (flush_now) begin
         valid_q <= '0;
      end else begin
         if (clr_line)   valid_q[fe_idx]   <= 1'b0;
         if (mark_valid) valid_q[miss_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_done) tag_q[miss_idx] <= line_q[LINE_W-1:IDX_W];
   end

   icache_data_ram #(
      .DEPTH (LINES * WORDS),
      .AW    (IDX_W + OFF_W)
   ) u_data_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .rd_en   (rd_en),
      .rd_clr  (rd_clr),
      .rd_addr ({fe_idx, fe_off}),
      .rd_data (fe_data),
      .wr_en   (wr_en),
      .wr_addr ({miss_idx, beat_q}),
      .wr_data (mem_rdata)
   );

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetches
// against a line-level cache model and an address-hashed memory.
module tb_icache;

   localparam int unsigned LINES = 64;
   localparam int unsigned WORDS = 4;
   localparam int unsigned OFF_W = $clog2(WORDS);
   localparam int unsigned IDX_W = $clog2(LINES);
   localparam int unsigned LN_LO = OFF_W + 2;

   logic        clk, reset_n;
   logic        fe_req, fe_ack, fe_error;
   logic [31:2] fe_addr;
   logic [31:0] fe_data;
   logic        mem_req, mem_ack, mem_error;
   logic [31:2] mem_addr;
   logic [31:0] mem_rdata;
`ifdef ICACHE_FLUSH_EN
   logic        ic_flush;
`endif

   int n_checks = 0;
   int n_errors = 0;

   bit              m_valid [LINES];
   logic [31:LN_LO] m_line  [LINES];

   logic [31:2] beats[$];
   int          req_cycles;
   int          wait_max, wait_left;
   bit          err_armed;
   logic [31:2] err_addr;
   int          err_beat;
   int          last_lat;

   icache #(.LINES(LINES), .WORDS(WORDS)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .fe_req    (fe_req),
      .fe_addr   (fe_addr),
      .fe_ack    (fe_ack),
      .fe_error  (fe_error),
      .fe_data   (fe_data),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_error (mem_error),
      .mem_rdata (mem_rdata)
`ifdef ICACHE_FLUSH_EN
      ,.ic_flush (ic_flush)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:2] a);
      return {a, 2'b00} ^ (32'(a) * 32'h9E37_79B1);
   endfunction

   function automatic bit model_hit(input logic [31:2] a);
      logic [IDX_W-1:0] i;
      i = a[IDX_W+LN_LO-1:LN_LO];
      return m_valid[i] && (m_line[i] == a[31:LN_LO]);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < int'(LINES); i++) m_valid[i] = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic arm_error(input logic [31:2] a, input int beat);
      err_armed = 1'b1;
      err_beat  = beat;
      err_addr  = {a[31:LN_LO], OFF_W'(beat)};
   endtask

   // Bus slave: random wait states, hashed data, one-shot error injection.
   initial begin
      mem_ack = 1'b0; mem_error = 1'b0; mem_rdata = '0; wait_left = 0;
      forever begin
         @(posedge clk); #1;
         mem_ack = 1'b0; mem_error = 1'b0; mem_rdata = $urandom;
         if (reset_n && mem_req) begin
            req_cycles++;
            if (wait_left == 0) begin
               mem_ack = 1'b1;
               beats.push_back(mem_addr);
               if (err_armed && mem_addr == err_addr) begin
                  mem_error = 1'b1;
                  err_armed = 1'b0;
               end else begin
                  mem_rdata = mem_word(mem_addr);
               end
               wait_left = $urandom_range(0, wait_max);
            end else begin
               wait_left--;
            end
         end
      end
   end

   // One fetch of a, optionally redirected to b at cycle redir_at; checks timing, bus beats and data.
   task automatic do_fetch(input logic [31:2] a, input int redir_at, input logic [31:2] b);
      bit              hit, err_here, exp_err;
      logic [31:2]     f, exp_ba;
      logic [IDX_W-1:0] ia;
      int              cyc, exp_lat, exp_nb;
      logic [31:0]     exp_data;
      hit      = model_hit(a);
      err_here = err_armed && !hit && (err_addr[31:LN_LO] == a[31:LN_LO]);
      f        = (redir_at >= 0) ? b : a;
      beats.delete();
      req_cycles = 0;
      @(posedge clk); #1;
      fe_req  = 1'b1;
      fe_addr = a;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (fe_ack || cyc > 300) break;
         @(posedge clk); #1;
         cyc++;
         if (cyc == redir_at) fe_addr = b;
      end
      ia = a[IDX_W+LN_LO-1:LN_LO];
      if (!hit) begin
         m_valid[ia] = 1'b0;
         if (!err_here) begin
            m_valid[ia] = 1'b1;
            m_line[ia]  = a[31:LN_LO];
         end
      end
      exp_err  = err_here && (f[31:LN_LO] == a[31:LN_LO]);
      exp_lat  = hit ? 0 : req_cycles + 1 + ((err_here && !exp_err) ? 1 : 0);
      exp_nb   = hit ? 0 : (err_here ? err_beat + 1 : int'(WORDS));
      exp_data = exp_err ? 32'h0 : mem_word(f);
      last_lat = cyc;
      check("ack", 32'(fe_ack), 32'd1);
      check("latency", cyc, exp_lat);
      check("fe_error", 32'(fe_error), 32'(exp_err));
      check("beat_count", beats.size(), exp_nb);
      for (int i = 0; i < beats.size() && i < exp_nb; i++) begin
         exp_ba = {a[31:LN_LO], OFF_W'(i)};
         check("beat_addr", 32'(beats[i]), 32'(exp_ba));
      end
      @(posedge clk); #1;
      fe_req = 1'b0;
      @(negedge clk);
      check("fe_data", fe_data, exp_data);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check("fe_data_hold", fe_data, exp_data);
      err_armed = 1'b0;
   endtask

   initial begin
      logic [31:2] a;
      int t;
      reset_n = 1'b0; fe_req = 1'b1; fe_addr = 30'h2000_0000;
      wait_max = 0; err_armed = 1'b0; err_addr = '0; err_beat = 0; req_cycles = 0;
`ifdef ICACHE_FLUSH_EN
      ic_flush = 1'b0;
`endif
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_fe_ack", 32'(fe_ack), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_fe_data", fe_data, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1; fe_req = 1'b0;

      do_fetch(30'h2000_0000, -1, '0);
      check("cold_latency", last_lat, WORDS + 1);
      do_fetch(30'h2000_0002, -1, '0);
      check("hit_latency", last_lat, 0);
      do_fetch(30'h2000_0000 + 30'(LINES * WORDS), -1, '0);
      do_fetch(30'h2000_0000, -1, '0);

      arm_error(30'h2000_0104, 2);
      do_fetch(30'h2000_0104, -1, '0);
      do_fetch(30'h2000_0104, -1, '0);

      do_fetch(30'h2000_0010, -1, '0);
      do_fetch(30'h2000_0204, 2, 30'h2000_0011);
      arm_error(30'h2000_0308, 1);
      do_fetch(30'h2000_0308, 2, 30'h2000_0012);

      // Reset in the middle of a refill.
      @(posedge clk); #1;
      fe_req = 1'b1; fe_addr = 30'h2000_0400;
      @(posedge clk); @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      check("rst_mid_mem_req", 32'(mem_req), 32'd0);
      check("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mid_fe_data", fe_data, 32'd0);
      fe_req = 1'b0;
      model_clear();
      @(posedge clk); #1;
      reset_n = 1'b1;
      do_fetch(30'h2000_0010, -1, '0);

`ifdef ICACHE_FLUSH_EN
      do_fetch(30'h2000_0011, -1, '0);
      @(posedge clk); #1 ic_flush = 1'b1;
      @(posedge clk); #1 ic_flush = 1'b0;
      model_clear();
      do_fetch(30'h2000_0010, -1, '0);
      @(posedge clk); #1;
      fe_req = 1'b1; fe_addr = 30'h2000_0020;
      @(posedge clk); #1 fe_req = 1'b0;
      @(posedge clk); #1 ic_flush = 1'b1;
      @(posedge clk); #1 ic_flush = 1'b0;
      t = 0;
      @(negedge clk);
      while (mem_req && t < 100) begin @(negedge clk); t++; end
      check("flush_refill_end", 32'(mem_req), 32'd0);
      model_clear();
      do_fetch(30'h2000_0020, -1, '0);
`endif

      wait_max = 2;
      repeat (200) begin
         a = 30'h2000_0000 + 30'($urandom_range(0, 2) * LINES * WORDS
                                + $urandom_range(0, 7) * WORDS
                                + $urandom_range(0, WORDS - 1));
         if ($urandom_range(0, 5) == 0) arm_error(a, $urandom_range(0, WORDS - 1));
         do_fetch(a, -1, '0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
